// File: rtl/stavka_pkg.sv
// Shared widths and parity-mode encoding for the stavka parity datapath.
package stavka_pkg;

  localparam int DATA_W = 7;
  localparam int CODE_W = 8;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_mode_e;

endpackage

// File: rtl/stavka_a_popcount7.sv
// Combinational population count of a 7-bit word (0..7); zero latency, no flow control.
module popcount7
  import stavka_pkg::*;
(
  input  logic [DATA_W-1:0] vec,
  output logic [2:0]        cnt
);

  always_comb begin
    cnt = 3'd0;
    for (int i = 0; i < DATA_W; i++) begin
      cnt = cnt + {2'b00, vec[i]};
    end
  end

endmodule

// File: rtl/stavka_a.sv
// Registered even/odd parity generator with popcount and saturating word statistics.
// One cycle latency, full throughput, no back-pressure: every in_valid cycle is accepted.
module stavka_a
  import stavka_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              control,
  output logic              out_valid,
  output logic [CODE_W-1:0] data_out,
  output logic [2:0]        ones_count,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  odd_word_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0] ones;
  logic       p;
  logic       parity_bit;

  popcount7 u_popcount7 (
    .vec (data_in),
    .cnt (ones)
  );

  // Odd number of ones in the payload is exactly the LSB of its popcount.
  assign p          = ones[0];
  assign parity_bit = p ^ (par_mode_e'(control) == PAR_ODD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      data_out       <= '0;
      ones_count     <= '0;
      word_count     <= '0;
      odd_word_count <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out   <= {parity_bit, data_in};
        ones_count <= ones;
        if (word_count != CNT_MAX) begin
          word_count <= word_count + CNT_ONE;
        end
        if (p && (odd_word_count != CNT_MAX)) begin
          odd_word_count <= odd_word_count + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_stavka_a.sv
// Bench for stavka_a: table-driven stimulus, queue scoreboard checked on the falling edge.
module tb_stavka_a;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] data_in = 7'h00;
  logic       control = 1'b0;

  logic        out_valid;
  logic [7:0]  data_out;
  logic [2:0]  ones_count;
  logic [15:0] word_count;
  logic [15:0] odd_word_count;

  logic        s_out_valid;
  logic [7:0]  s_data_out;
  logic [2:0]  s_ones_count;
  logic [3:0]  s_word_count;
  logic [3:0]  s_odd_word_count;

  stavka_a #(.CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .data_in        (data_in),
    .control        (control),
    .out_valid      (out_valid),
    .data_out       (data_out),
    .ones_count     (ones_count),
    .word_count     (word_count),
    .odd_word_count (odd_word_count)
  );

  stavka_a #(.CNT_W(4)) dut_small (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .data_in        (data_in),
    .control        (control),
    .out_valid      (s_out_valid),
    .data_out       (s_data_out),
    .ones_count     (s_ones_count),
    .word_count     (s_word_count),
    .odd_word_count (s_odd_word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] d;
    logic       c;
    logic [7:0] e_dout;
    logic [2:0] e_ones;
  } vec_t;

  typedef struct packed {
    int         due;
    logic [6:0] d;
    logic       c;
    logic [7:0] e_dout;
    logic [2:0] e_ones;
  } exp_t;

  vec_t tbl[$];
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_smp = 1'b0;

  int exp_wc = 0, exp_owc = 0, exp_wc4 = 0, exp_owc4 = 0;
  logic [7:0] last_dout = 8'h00;
  logic [2:0] last_ones = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= rst_n;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_smp) begin
      exp_wc = 0; exp_owc = 0; exp_wc4 = 0; exp_owc4 = 0;
      last_dout = 8'h00; last_ones = 3'd0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_ones_count", ones_count, 0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("out_valid_pulse", out_valid, 1);
      chk("data_out", data_out, e.e_dout);
      chk("ones_count", ones_count, e.e_ones);
      chk("payload_passthru", data_out[6:0], e.d);
      chk("codeword_parity", ^data_out, e.c);
      exp_wc  = sat_inc(exp_wc, 65535);
      exp_wc4 = sat_inc(exp_wc4, 15);
      if ($countones(e.d) % 2 == 1) begin
        exp_owc  = sat_inc(exp_owc, 65535);
        exp_owc4 = sat_inc(exp_owc4, 15);
      end
      last_dout = e.e_dout;
      last_ones = e.e_ones;
    end else begin
      chk("idle_out_valid", out_valid, 0);
      chk("hold_data_out", data_out, last_dout);
      chk("hold_ones_count", ones_count, last_ones);
    end
    chk("word_count", word_count, exp_wc);
    chk("odd_word_count", odd_word_count, exp_owc);
    chk("word_count_w4", s_word_count, exp_wc4);
    chk("odd_word_count_w4", s_odd_word_count, exp_owc4);
  end

  task automatic drive(input logic v, input logic [6:0] d, input logic c, input logic r,
                       input logic [7:0] e_dout, input logic [2:0] e_ones);
    @(posedge clk);
    #1;
    rst_n    = r;
    in_valid = v;
    data_in  = d;
    control  = c;
    if (r && v) q.push_back('{due: cyc + 1, d: d, c: c, e_dout: e_dout, e_ones: e_ones});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 7'h00, 1'b0, 1'b1, 8'h00, 3'd0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 7'h2A, 1'b1, 1'b0, 8'h00, 3'd0);
  endtask

  initial begin
    // Sweep entries: even mode sets the parity bit when the payload has odd weight.
    for (int k = 0; k < 256; k++) begin
      logic [6:0] d;
      logic       c;
      int         n;
      d = 7'(k >> 1);
      c = k[0];
      n = $countones(d);
      tbl.push_back('{d: d, c: c, e_dout: {(n % 2 == 1) ^ c, d}, e_ones: 3'(n)});
    end
    tbl.push_back('{d: 7'h00, c: 1'b0, e_dout: 8'h00, e_ones: 3'd0});
    tbl.push_back('{d: 7'h00, c: 1'b1, e_dout: 8'h80, e_ones: 3'd0});
    tbl.push_back('{d: 7'h7F, c: 1'b0, e_dout: 8'hFF, e_ones: 3'd7});
    tbl.push_back('{d: 7'h03, c: 1'b1, e_dout: 8'h83, e_ones: 3'd2});

    do_reset(3);

    for (int i = 0; i < 256; i++) drive(1'b1, tbl[i].d, tbl[i].c, 1'b1, tbl[i].e_dout, tbl[i].e_ones);
    idle(2);
    @(negedge clk);
    chk("sweep_word_count", word_count, 256);
    chk("sweep_odd_word_count", odd_word_count, 128);

    for (int i = 256; i < tbl.size(); i++) drive(1'b1, tbl[i].d, tbl[i].c, 1'b1, tbl[i].e_dout, tbl[i].e_ones);
    idle(1);

    // Single word followed by idle cycles: pulse once, then hold.
    do_reset(1);
    drive(1'b1, 7'h01, 1'b0, 1'b1, 8'h81, 3'd1);
    idle(2);
    @(negedge clk);
    chk("gap_hold_data_out", data_out, 8'h81);
    chk("gap_out_valid_low", out_valid, 0);
    chk("gap_word_count", word_count, 1);

    do_reset(1);
    for (int i = 0; i < 20; i++) drive(1'b1, 7'h01, 1'b0, 1'b1, 8'h81, 3'd1);
    idle(1);
    @(negedge clk);
    chk("sat_word_count_w4", s_word_count, 15);
    chk("sat_odd_word_count_w4", s_odd_word_count, 15);
    chk("sat_word_count_w16", word_count, 20);

    for (int i = 0; i < 5; i++) drive(1'b1, 7'(i * 9 + 3), 1'b0, 1'b1,
                                      {($countones(7'(i * 9 + 3)) % 2 == 1), 7'(i * 9 + 3)},
                                      3'($countones(7'(i * 9 + 3))));
    drive(1'b1, 7'h33, 1'b0, 1'b0, 8'h00, 3'd0);
    // 0x55 has four ones, so odd mode sets the parity bit.
    drive(1'b1, 7'h55, 1'b1, 1'b1, 8'hD5, 3'd4);
    idle(1);
    @(negedge clk);
    chk("midrst_data_out", data_out, 8'hD5);
    chk("midrst_ones_count", ones_count, 4);
    chk("midrst_word_count", word_count, 1);
    chk("midrst_odd_word_count", odd_word_count, 0);

    idle(3);
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
